// File: rtl/regfile_write_queue.sv
// Write queue ahead of the 32x32 register array with a youngest-match read bypass.
// Latency: an accepted write is presented to the array the following cycle. in_ready drops only when the queue is full.
module regfile_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_addr,
  input  logic [DW-1:0]              in_data,
  input  logic                       reg_stall,
  output logic                       wr_en,
  output logic [AW-1:0]              wr_addr,
  output logic [DW-1:0]              wr_data,
  input  logic [AW-1:0]              rd_addr,
  output logic                       byp_hit,
  output logic [DW-1:0]              byp_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic            enq;
  logic            deq;
  logic            not_empty;

  assign not_empty = (count != '0);
  assign in_ready  = (count != CW'(DEPTH));
  // Writes to register 0 complete the handshake but never occupy a slot.
  assign enq       = in_valid && in_ready && (in_addr != '0);
  assign deq       = wr_en;

  assign wr_en   = not_empty && !reg_stall;
  assign wr_addr = not_empty ? mem[head].addr : '0;
  assign wr_data = not_empty ? mem[head].data : '0;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    byp_hit  = 1'b0;
    byp_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < count) && (rd_addr != '0) && (mem[idx].addr == rd_addr)) begin
        byp_hit  = 1'b1;
        byp_data = mem[idx].data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (enq) begin
        mem[tail] <= '{addr: in_addr, data: in_data};
        tail      <= tail + 1'b1;
      end
      if (deq) begin
        head <= head + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed bench for regfile_write_queue: drain order, bypass, r0 drop, wrap and async reset.
module tb_regfile_write_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        reg_stall;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr;
  logic        byp_hit;
  logic [31:0] byp_data;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  regfile_write_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .reg_stall(reg_stall),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .byp_hit  (byp_hit),
    .byp_data (byp_data),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_addr   = '0;
    in_data   = '0;
    reg_stall = 1'b0;
    rd_addr   = '0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_wr_en", wr_en, 0);
    check("rst_byp_hit", byp_hit, 0);
    check("rst_count", count, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_byp_data", byp_data, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // single write, one-cycle latency
    push(5'd5, 32'hDEADBEEF);
    #1;
    check("t1_wr_en", wr_en, 1);
    check("t1_wr_addr", wr_addr, 5);
    check("t1_wr_data", wr_data, 32'hDEADBEEF);
    check("t1_count", count, 1);
    tick();
    check("t1_count_after", count, 0);
    check("t1_wr_en_after", wr_en, 0);

    // fill under stall, then drain in order
    reg_stall = 1'b1;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'(i * 'h11));
    #1;
    check("t2_count_full", count, 4);
    check("t2_in_ready_full", in_ready, 0);
    check("t2_wr_en_stalled", wr_en, 0);
    reg_stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check("t2_drain_en", wr_en, 1);
      check("t2_drain_addr", wr_addr, 5'(i));
      check("t2_drain_data", wr_data, 32'(i * 'h11));
      check("t2_in_ready", in_ready, (i > 1) ? 1 : 0);
      tick();
    end
    check("t2_count_empty", count, 0);

    // bypass picks the youngest of two writes to r7
    reg_stall = 1'b1;
    push(5'd7, 32'hA);
    push(5'd7, 32'hB);
    rd_addr = 5'd7;
    #1;
    check("t3_hit", byp_hit, 1);
    check("t3_data", byp_data, 32'hB);
    check("t3_head_data", wr_data, 32'hA);
    rd_addr = 5'd8;
    #1;
    check("t3_miss_hit", byp_hit, 0);
    check("t3_miss_data", byp_data, 0);
    rd_addr   = 5'd7;
    reg_stall = 1'b0;
    #1;
    check("t3_hit_draining", byp_data, 32'hB);
    tick();
    check("t3_hit_last", byp_hit, 1);
    check("t3_data_last", byp_data, 32'hB);
    tick();
    check("t3_empty", count, 0);
    check("t3_no_hit", byp_hit, 0);

    // writes to r0 are dropped
    rd_addr  = 5'd0;
    in_valid = 1'b1;
    in_addr  = 5'd0;
    in_data  = 32'hFFFFFFFF;
    #1;
    check("t4_ready", in_ready, 1);
    check("t4_hit", byp_hit, 0);
    tick();
    in_valid = 1'b0;
    #1;
    check("t4_count", count, 0);
    check("t4_wr_en", wr_en, 0);

    // streaming with no stall: count stays 1, pointers wrap
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1'b1;
      in_addr  = 5'(i);
      in_data  = 32'h100 + 32'(i);
      #1;
      if (i > 1) begin
        check("t5_count", count, 1);
        check("t5_wr_en", wr_en, 1);
        check("t5_wr_addr", wr_addr, 5'(i - 1));
        check("t5_wr_data", wr_data, 32'h100 + 32'(i - 1));
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("t5_last_addr", wr_addr, 10);
    check("t5_last_data", wr_data, 32'h10A);
    tick();
    check("t5_empty", count, 0);

    // async reset mid-cycle discards pending writes
    reg_stall = 1'b1;
    push(5'd3, 32'h33);
    push(5'd4, 32'h44);
    push(5'd5, 32'h55);
    rd_addr = 5'd3;
    #1;
    check("t6_count", count, 3);
    check("t6_hit_pre", byp_hit, 1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_count", count, 0);
    check("t6_rst_wr_en", wr_en, 0);
    check("t6_rst_hit", byp_hit, 0);
    check("t6_rst_ready", in_ready, 1);
    tick();
    reset_n   = 1'b1;
    reg_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t6_no_stale", wr_en, 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
